// File: rtl/simple_processor_top_core_pkg.sv
// Shared types for the simple processor: data width, opcodes, step encoding
// and bus source selection.
package simple_processor_top_core_pkg;

  localparam int DW = 9;

  typedef logic [DW-1:0] word_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_R    = 3'd1,
    SEL_A    = 3'd2,
    SEL_G    = 3'd3,
    SEL_DIN  = 3'd4
  } bus_sel_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/simple_processor_top_core_if.sv
// Run/DIN request side and Bus/Done observation side of the processor.
interface simple_processor_top_core_if;
  import simple_processor_top_core_pkg::*;

  logic  Run;
  word_t DIN;
  word_t Bus;
  logic  Done;

  modport master (output Run, output DIN, input Bus, input Done);
  modport slave  (input Run, input DIN, output Bus, output Done);

endinterface

// File: rtl/simple_processor_top_core_regn.sv
// Data-width register with load enable and asynchronous active-high clear.
module simple_processor_top_core_regn
  import simple_processor_top_core_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  ld_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/simple_processor_top_core.sv
// Multi-cycle processor: step counter T0..T3, shared bus mux, add/sub unit,
// eight general registers plus A, G and IR.
module simple_processor_top_core
  import simple_processor_top_core_pkg::*;
(
  input  logic Clock,
  input  logic Resetn,
  simple_processor_top_core_if.slave io
);

  step_t    step_q;
  word_t    ir_q;
  word_t    a_q;
  word_t    g_q;
  word_t    r_q [8];
  word_t    bus;
  word_t    alu_d;
  bus_sel_t sel;
  logic [2:0] sel_idx;
  logic [7:0] r_ld;
  logic       a_ld;
  logic       g_ld;
  logic       ir_ld;
  logic       done;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  assign op = ir_q[2:0];
  assign rx = ir_q[5:3];
  assign ry = ir_q[8:6];

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      step_q <= T0;
    end else begin
      case (step_q)
        T0:      if (io.Run) step_q <= T1;
        T1:      step_q <= is_arith(op) ? T2 : T0;
        T2:      step_q <= T3;
        default: step_q <= T0;
      endcase
    end
  end

  // Control decode; reset forces step_q to T0, which keeps Bus and Done at 0.
  always_comb begin
    sel     = SEL_NONE;
    sel_idx = 3'd0;
    r_ld    = 8'd0;
    a_ld    = 1'b0;
    g_ld    = 1'b0;
    ir_ld   = 1'b0;
    done    = 1'b0;
    case (step_q)
      T0: ir_ld = io.Run;
      T1: begin
        case (op)
          OP_MV: begin
            sel       = SEL_R;
            sel_idx   = ry;
            r_ld[rx]  = 1'b1;
            done      = 1'b1;
          end
          OP_MVI: begin
            sel       = SEL_DIN;
            r_ld[rx]  = 1'b1;
            done      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel     = SEL_R;
            sel_idx = rx;
            a_ld    = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        sel     = SEL_R;
        sel_idx = ry;
        g_ld    = 1'b1;
      end
      default: begin
        sel      = SEL_G;
        r_ld[rx] = 1'b1;
        done     = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (sel)
      SEL_R:   bus = r_q[sel_idx];
      SEL_A:   bus = a_q;
      SEL_G:   bus = g_q;
      SEL_DIN: bus = io.DIN;
      default: bus = '0;
    endcase
  end

  // Modulo-512 arithmetic; carry and borrow are dropped.
  assign alu_d = (op == OP_SUB) ? (a_q - bus) : (a_q + bus);

  assign io.Bus  = bus;
  assign io.Done = done;

  for (genvar gi = 0; gi < 8; gi++) begin : g_r
    simple_processor_top_core_regn u_r (
      .clk_i (Clock),
      .rst_i (Resetn),
      .ld_i  (r_ld[gi]),
      .d_i   (bus),
      .q_o   (r_q[gi])
    );
  end

  simple_processor_top_core_regn u_a (
    .clk_i (Clock),
    .rst_i (Resetn),
    .ld_i  (a_ld),
    .d_i   (bus),
    .q_o   (a_q)
  );

  simple_processor_top_core_regn u_g (
    .clk_i (Clock),
    .rst_i (Resetn),
    .ld_i  (g_ld),
    .d_i   (alu_d),
    .q_o   (g_q)
  );

  simple_processor_top_core_regn u_ir (
    .clk_i (Clock),
    .rst_i (Resetn),
    .ld_i  (ir_ld),
    .d_i   (io.DIN),
    .q_o   (ir_q)
  );

endmodule

// File: tb/tb_simple_processor_top_core.sv
// Directed bench for simple_processor_top_core with hand-computed expectations.
module tb_simple_processor_top_core;
  import simple_processor_top_core_pkg::*;

  logic Clock;
  logic Resetn;
  int   total;
  int   bad;

  simple_processor_top_core_if bus_if ();

  simple_processor_top_core dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .io     (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // mvi with Run left high so the next instruction fetches right after Done.
  task automatic do_mvi(input logic [2:0] rx, input logic [8:0] imm);
    bus_if.DIN = {3'b000, rx, 3'b001};
    bus_if.Run = 1'b1;
    cyc();
    bus_if.DIN = imm;
    #1;
    chk("mvi_t1_done", 9'(bus_if.Done), 9'd1);
    chk("mvi_t1_bus", bus_if.Bus, imm);
    cyc();
    chk("mvi_result", dut.r_q[rx], imm);
  endtask

  initial begin
    total = 0;
    bad = 0;
    Resetn = 1'b1;
    bus_if.Run = 1'b0;
    bus_if.DIN = 9'd0;
    cyc();
    cyc();
    chk("rst_done", 9'(bus_if.Done), 9'd0);
    chk("rst_bus", bus_if.Bus, 9'd0);
    chk("rst_step", 9'(dut.step_q), 9'd0);
    chk("rst_r0", dut.r_q[0], 9'd0);

    // mvi R0, 111110000 straight out of reset
    Resetn = 1'b0;
    bus_if.DIN = 9'b011_000_001;
    bus_if.Run = 1'b1;
    cyc();
    chk("first_fetch_step", 9'(dut.step_q), 9'd1);
    bus_if.DIN = 9'b111110000;
    #1;
    chk("mvi_r0_done", 9'(bus_if.Done), 9'd1);
    chk("mvi_r0_bus", bus_if.Bus, 9'b111110000);
    cyc();
    chk("mvi_r0_val", dut.r_q[0], 9'b111110000);

    do_mvi(3'd2, 9'b100001111);
    do_mvi(3'd1, 9'b101010101);
    chk("r2_kept", dut.r_q[2], 9'b100001111);

    // sub R0,R2
    bus_if.DIN = 9'b010_000_010;
    cyc();
    chk("sub_t1_bus", bus_if.Bus, 9'b111110000);
    chk("sub_t1_done", 9'(bus_if.Done), 9'd0);
    cyc();
    chk("sub_t2_bus", bus_if.Bus, 9'b100001111);
    chk("sub_t2_done", 9'(bus_if.Done), 9'd0);
    cyc();
    chk("sub_t3_bus", bus_if.Bus, 9'b011100001);
    chk("sub_t3_done", 9'(bus_if.Done), 9'd1);
    cyc();
    chk("sub_r0", dut.r_q[0], 9'b011100001);
    chk("sub_t0_bus", bus_if.Bus, 9'd0);

    // add R1,R1 with Run dropped right after fetch
    bus_if.DIN = 9'b001_001_011;
    cyc();
    bus_if.Run = 1'b0;
    #1;
    chk("add_t1_bus", bus_if.Bus, 9'b101010101);
    cyc();
    chk("add_t2_step", 9'(dut.step_q), 9'd2);
    cyc();
    chk("add_t3_bus", bus_if.Bus, 9'b010101010);
    chk("add_t3_done", 9'(bus_if.Done), 9'd1);
    cyc();
    chk("add_r1_wrap", dut.r_q[1], 9'b010101010);
    cyc();
    chk("add_idle_step", 9'(dut.step_q), 9'd0);

    // mv R7,R1 then idle
    bus_if.DIN = 9'b001_111_000;
    bus_if.Run = 1'b1;
    cyc();
    bus_if.Run = 1'b0;
    #1;
    chk("mv_t1_bus", bus_if.Bus, 9'b010101010);
    chk("mv_t1_done", 9'(bus_if.Done), 9'd1);
    cyc();
    chk("mv_r7", dut.r_q[7], 9'b010101010);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_step", 9'(dut.step_q), 9'd0);
      chk("idle_done", 9'(bus_if.Done), 9'd0);
      chk("idle_bus", bus_if.Bus, 9'd0);
    end

    // sub R3,R3 uses the pre-write value
    do_mvi(3'd3, 9'd5);
    bus_if.DIN = 9'b011_011_010;
    cyc();
    bus_if.Run = 1'b0;
    cyc();
    cyc();
    chk("sub_self_bus", bus_if.Bus, 9'd0);
    cyc();
    chk("sub_self_r3", dut.r_q[3], 9'd0);

    // opcode 101 is a NOP
    bus_if.DIN = 9'b000_100_101;
    bus_if.Run = 1'b1;
    cyc();
    bus_if.Run = 1'b0;
    #1;
    chk("nop_done", 9'(bus_if.Done), 9'd1);
    chk("nop_bus", bus_if.Bus, 9'd0);
    cyc();
    chk("nop_step", 9'(dut.step_q), 9'd0);
    chk("nop_r4", dut.r_q[4], 9'd0);

    // reset in T2 of add R5,R5
    do_mvi(3'd5, 9'd10);
    bus_if.DIN = 9'b101_101_011;
    cyc();
    bus_if.Run = 1'b0;
    cyc();
    chk("arst_pre_step", 9'(dut.step_q), 9'd2);
    Resetn = 1'b1;
    #1;
    chk("arst_step", 9'(dut.step_q), 9'd0);
    chk("arst_r5", dut.r_q[5], 9'd0);
    chk("arst_r1", dut.r_q[1], 9'd0);
    chk("arst_a", dut.a_q, 9'd0);
    chk("arst_done", 9'(bus_if.Done), 9'd0);
    chk("arst_bus", bus_if.Bus, 9'd0);
    cyc();
    cyc();
    chk("arst_hold_r5", dut.r_q[5], 9'd0);
    Resetn = 1'b0;
    bus_if.DIN = 9'b000_110_001;
    bus_if.Run = 1'b1;
    cyc();
    chk("post_rst_fetch", 9'(dut.step_q), 9'd1);
    bus_if.DIN = 9'd77;
    cyc();
    chk("post_rst_r6", dut.r_q[6], 9'd77);
    chk("post_rst_r5", dut.r_q[5], 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
